ram_dp_param: RTL and testbench

Parametrised single-clock simple-dual-port RAM: the next generation of the team's `ram` block, with a separate write port and read port usable in the same cycle. Width and depth are set by parameters. A hardware initialisation sequencer clears the whole array after every reset. An optional per-word parity check can be compiled in. It is the storage element that `ram_tb_top`-style benches instantiate as `DUT`.

---
 rtl/ram_dp_param.sv | 122 ++++++++++++
 tb/tb_ram_dp_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// Single-clock simple-dual-port RAM with a hardware clear sequencer that runs after every reset.
// Optional per-word even parity is enabled by defining RAM_PARITY_EN.
module ram_dp_param #(
    parameter int unsigned            DATA_WIDTH = 8,
    parameter int unsigned            ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  init_busy
`ifdef RAM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_PARITY_EN
    localparam int unsigned WORD_W = DATA_WIDTH + 1;
`else
    localparam int unsigned WORD_W = DATA_WIDTH;
`endif

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   init_cnt_q;
    logic [WORD_W-1:0]       mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [WORD_W-1:0]       mem_wword;
    logic                    rd_accept;
    logic                    collision;
    logic [WORD_W-1:0]       rd_word;

    // The sequencer owns the write port while initialising; user requests are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = data_in;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q;
            mem_wdata = INIT_VALUE;
        end else if (wr_enb) begin
            mem_we = 1'b1;
        end
    end

`ifdef RAM_PARITY_EN
    assign mem_wword = {^mem_wdata, mem_wdata};
`else
    assign mem_wword = mem_wdata;
`endif

    assign rd_accept = (state_q == StReady) && rd_enb;
    assign collision = rd_accept && wr_enb && (wr_addr == rd_addr);
    // Write-first: a same-address read sees the word being written this edge.
    assign rd_word   = collision ? mem_wword : mem[rd_addr];

    // No reset on the array: contents are left alone while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wword;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            init_busy  <= 1'b1;
            data_out   <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                data_out <= rd_word[DATA_WIDTH-1:0];
            end
            unique case (state_q)
                StInit: begin
                    init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
                    if (init_cnt_q == '1) begin
                        state_q   <= StReady;
                        init_busy <= 1'b0;
                    end
                end
                StReady: begin
                    state_q <= StReady;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

`ifdef RAM_PARITY_EN
    logic rd_par_bad;

    // Stored bit is even parity over the data, so any odd total flags corruption.
    assign rd_par_bad = rd_word[DATA_WIDTH] ^ (^rd_word[DATA_WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_accept && rd_par_bad;
        end
    end
`endif

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed self-checking bench for ram_dp_param (DATA_WIDTH 8, ADDR_WIDTH 4, INIT_VALUE 8'hA5).
// Define RAM_PARITY_EN for both files to exercise the parity check.
module tb_ram_dp_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_enb;
    logic [3:0] wr_addr;
    logic [7:0] data_in;
    logic       rd_enb;
    logic [3:0] rd_addr;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       init_busy;
`ifdef RAM_PARITY_EN
    logic       parity_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    ram_dp_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .INIT_VALUE(8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_enb    (wr_enb),
        .wr_addr   (wr_addr),
        .data_in   (data_in),
        .rd_enb    (rd_enb),
        .rd_addr   (rd_addr),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .init_busy (init_busy)
`ifdef RAM_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_enb  = 1'b0;
        rd_enb  = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        data_in = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data_out: got %h expected 00", data_out);
        end
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rd_valid: got %b expected 0", rd_valid);
        end
        vectors++;
        if (init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_init_busy: got %b expected 1", init_busy);
        end
`ifdef RAM_PARITY_EN
        vectors++;
        if (parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_parity_err: got %b expected 0", parity_err);
        end
`endif
    endtask

    // Release reset with requests held high; they must be ignored during the sweep.
    task automatic test_init_busy_masking();
        int  cycles = 0;
        bit  saw_valid = 0;
        wr_enb  = 1'b1;
        wr_addr = 4'd2;
        data_in = 8'hFF;
        rd_enb  = 1'b1;
        rd_addr = 4'd2;
        rst     = 1'b0;
        do begin
            step();
            cycles++;
            if (rd_valid !== 1'b0) saw_valid = 1;
        end while (init_busy !== 1'b0 && cycles < 40);
        idle();
        vectors++;
        if (cycles != 16) begin
            miscompares++;
            $display("FAIL init_length: got %0d cycles expected 16", cycles);
        end
        vectors++;
        if (saw_valid) begin
            miscompares++;
            $display("FAIL init_rd_masked: got rd_valid 1 during init expected 0");
        end
        rd_enb  = 1'b1;
        rd_addr = 4'd2;
        step();
        idle();
        vectors++;
        if (data_out !== 8'hA5 || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL init_wr_masked: got %h/%b expected a5/1", data_out, rd_valid);
        end
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < 16; i++) begin
            rd_enb  = 1'b1;
            rd_addr = 4'(i);
            step();
            vectors++;
            if (data_out !== 8'hA5 || rd_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL sweep_addr%0d: got %h/%b expected a5/1", i, data_out, rd_valid);
            end
        end
        idle();
        step();
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_valid_drop: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_write_readback();
        wr_enb = 1'b1; wr_addr = 4'd5;  data_in = 8'h3C;
        step();
        wr_addr = 4'd10; data_in = 8'hC3;
        step();
        // Independent write to 12 while reading 5.
        wr_addr = 4'd12; data_in = 8'h5A;
        rd_enb  = 1'b1;  rd_addr = 4'd5;
        step();
        wr_enb = 1'b0;
        vectors++;
        if (data_out !== 8'h3C || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL readback_5: got %h/%b expected 3c/1", data_out, rd_valid);
        end
        rd_addr = 4'd10;
        step();
        vectors++;
        if (data_out !== 8'hC3 || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL readback_10: got %h/%b expected c3/1", data_out, rd_valid);
        end
        rd_addr = 4'd12;
        step();
        vectors++;
        if (data_out !== 8'h5A || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL readback_12: got %h/%b expected 5a/1", data_out, rd_valid);
        end
        idle();
        step();
        vectors++;
        if (data_out !== 8'h5A || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL readback_hold: got %h/%b expected 5a/0", data_out, rd_valid);
        end
    endtask

    task automatic test_collision();
        wr_enb = 1'b1; wr_addr = 4'd3; data_in = 8'h77;
        rd_enb = 1'b1; rd_addr = 4'd3;
        step();
        wr_enb = 1'b0;
        vectors++;
        if (data_out !== 8'h77 || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL collision: got %h/%b expected 77/1", data_out, rd_valid);
        end
        step();
        idle();
        vectors++;
        if (data_out !== 8'h77 || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_persist: got %h/%b expected 77/1", data_out, rd_valid);
        end
    endtask

    task automatic test_mid_reset();
        int cycles = 0;
        wr_enb = 1'b1; wr_addr = 4'd7; data_in = 8'h11;
        rd_enb = 1'b1; rd_addr = 4'd7;
        step();
        wr_enb = 1'b0;
        vectors++;
        if (data_out !== 8'h11 || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: got %h/%b expected 11/1", data_out, rd_valid);
        end
        // Read still requested on the reset edge; it must be discarded.
        rst = 1'b1;
        step();
        vectors++;
        if (data_out !== 8'h00 || rd_valid !== 1'b0 || init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %h/%b/%b expected 00/0/1",
                     data_out, rd_valid, init_busy);
        end
        rst = 1'b0;
        idle();
        do begin
            step();
            cycles++;
        end while (init_busy !== 1'b0 && cycles < 40);
        vectors++;
        if (cycles != 16) begin
            miscompares++;
            $display("FAIL midrst_reinit: got %0d cycles expected 16", cycles);
        end
        rd_enb = 1'b1; rd_addr = 4'd7;
        step();
        idle();
        vectors++;
        if (data_out !== 8'hA5 || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_addr7: got %h/%b expected a5/1", data_out, rd_valid);
        end
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        wr_enb = 1'b1; wr_addr = 4'd4; data_in = 8'h0F;
        step();
        idle();
        dut.mem[4][0] = ~dut.mem[4][0];
        rd_enb = 1'b1; rd_addr = 4'd4;
        step();
        vectors++;
        if (parity_err !== 1'b1 || rd_valid !== 1'b1 || data_out !== 8'h0E) begin
            miscompares++;
            $display("FAIL parity_bad: got %b/%b/%h expected 1/1/0e",
                     parity_err, rd_valid, data_out);
        end
        rd_addr = 4'd5;
        step();
        vectors++;
        if (parity_err !== 1'b0 || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_good: got %b/%b expected 0/1", parity_err, rd_valid);
        end
        rd_addr = 4'd4;
        step();
        idle();
        step();
        vectors++;
        if (parity_err !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_clear: got %b/%b expected 0/0", parity_err, rd_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init_busy_masking();
        test_init_sweep();
        test_write_readback();
        test_collision();
        test_mid_reset();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
